// File: rtl/fp_align_add_if.sv
// Operand and result bundle for the FP32 align/add stage.
// The slave modport is the datapath side; the master modport drives operands and accepts results.
interface fp_align_add_if #(
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 24,
    parameter int OUT_MANT_W = MANT_W + 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  op_sub;
    logic                  sign_a;
    logic                  sign_b;
    logic [EXP_W-1:0]      exp_a;
    logic [EXP_W-1:0]      exp_b;
    logic [MANT_W-1:0]     mant_a;
    logic [MANT_W-1:0]     mant_b;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [EXP_W-1:0]      out_exp;
    logic [OUT_MANT_W-1:0] out_mant;
    logic                  out_inf;
    logic                  out_nan;

    modport master (
        output in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_inf, out_nan
    );

    modport slave (
        input  in_valid, op_sub, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_inf, out_nan
    );
endinterface

// File: rtl/fp_align_add.sv
// Two-stage FP32 exponent-align and mantissa add/subtract.
// Stage 1 orders the operands, aligns the smaller mantissa with sticky, and classifies specials.
// Stage 2 adds or subtracts the aligned mantissas and produces the unnormalized result.
module fp_align_add #(
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 24,
    parameter int OUT_MANT_W = MANT_W + 4
) (
    input logic            clk,
    input logic            rst_n,
    fp_align_add_if.slave  bus
);
    localparam int ALIGN_W = MANT_W + 3;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic                  s1_valid;
    logic [ALIGN_W-1:0]    s1_big;
    logic [ALIGN_W-1:0]    s1_small;
    logic                  s1_sign_big;
    logic                  s1_eff_sub;
    logic [EXP_W-1:0]      s1_exp_big;
    logic                  s1_nan;
    logic                  s1_inf;
    logic                  s1_inf_sign;

    logic                  s2_valid;
    logic                  s2_sign;
    logic [EXP_W-1:0]      s2_exp;
    logic [OUT_MANT_W-1:0] s2_mant;
    logic                  s2_inf;
    logic                  s2_nan;

    logic                  s2_ready;
    logic                  in_ready;

    logic                  eff_sign_b;
    logic [EXP_W-1:0]      eff_exp_a;
    logic [EXP_W-1:0]      eff_exp_b;
    logic                  a_big;
    logic [EXP_W-1:0]      exp_diff;
    logic [MANT_W-1:0]     mant_big;
    logic [MANT_W-1:0]     mant_small;
    logic [ALIGN_W-1:0]    small_ext;
    logic [ALIGN_W-1:0]    lost_mask;
    logic [ALIGN_W-1:0]    aligned;
    logic                  nan_a;
    logic                  nan_b;
    logic                  inf_a;
    logic                  inf_b;
    logic                  any_nan;

    logic [OUT_MANT_W-1:0] sum_mant;
    logic [OUT_MANT_W-1:0] diff_mant;
    logic                  res_sign;
    logic [EXP_W-1:0]      res_exp;
    logic [OUT_MANT_W-1:0] res_mant;

    assign s2_ready      = !s2_valid || bus.out_ready;
    assign in_ready      = !s1_valid || s2_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_sign  = s2_sign;
    assign bus.out_exp   = s2_exp;
    assign bus.out_mant  = s2_mant;
    assign bus.out_inf   = s2_inf;
    assign bus.out_nan   = s2_nan;

    // Order the operands by magnitude, align the smaller one with sticky, and classify specials.
    always_comb begin
        eff_sign_b = bus.sign_b ^ bus.op_sub;
        eff_exp_a  = (bus.exp_a == '0) ? EXP_W'(1) : bus.exp_a;
        eff_exp_b  = (bus.exp_b == '0) ? EXP_W'(1) : bus.exp_b;
        a_big      = {eff_exp_a, bus.mant_a} >= {eff_exp_b, bus.mant_b};
        if (a_big) begin
            mant_big   = bus.mant_a;
            mant_small = bus.mant_b;
            exp_diff   = eff_exp_a - eff_exp_b;
        end else begin
            mant_big   = bus.mant_b;
            mant_small = bus.mant_a;
            exp_diff   = eff_exp_b - eff_exp_a;
        end
        small_ext = {mant_small, 3'b000};
        lost_mask = '0;
        aligned   = '0;
        if (exp_diff >= EXP_W'(ALIGN_W)) begin
            aligned = {{(ALIGN_W-1){1'b0}}, |mant_small};
        end else begin
            lost_mask  = ~({ALIGN_W{1'b1}} << exp_diff);
            aligned    = small_ext >> exp_diff;
            aligned[0] = aligned[0] | (|(small_ext & lost_mask));
        end
        nan_a   = (bus.exp_a == EXP_MAX) && (bus.mant_a[MANT_W-2:0] != '0);
        nan_b   = (bus.exp_b == EXP_MAX) && (bus.mant_b[MANT_W-2:0] != '0);
        inf_a   = (bus.exp_a == EXP_MAX) && (bus.mant_a[MANT_W-2:0] == '0);
        inf_b   = (bus.exp_b == EXP_MAX) && (bus.mant_b[MANT_W-2:0] == '0);
        any_nan = nan_a || nan_b || (inf_a && inf_b && (bus.sign_a != eff_sign_b));
    end

    // Stage 1 register: captures the ordered, aligned operand pair when the stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_big      <= '0;
            s1_small    <= '0;
            s1_sign_big <= 1'b0;
            s1_eff_sub  <= 1'b0;
            s1_exp_big  <= '0;
            s1_nan      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_big      <= {mant_big, 3'b000};
                s1_small    <= aligned;
                s1_sign_big <= a_big ? bus.sign_a : eff_sign_b;
                s1_eff_sub  <= bus.sign_a ^ eff_sign_b;
                s1_exp_big  <= a_big ? bus.exp_a : bus.exp_b;
                s1_nan      <= any_nan;
                s1_inf      <= !any_nan && (inf_a || inf_b);
                s1_inf_sign <= inf_a ? bus.sign_a : eff_sign_b;
            end
        end
    end

    // Add or subtract the aligned mantissas; specials and exact cancellation override the sum.
    always_comb begin
        sum_mant  = {1'b0, s1_big} + {1'b0, s1_small};
        diff_mant = {1'b0, s1_big} - {1'b0, s1_small};
        res_sign  = s1_sign_big;
        res_exp   = s1_exp_big;
        res_mant  = s1_eff_sub ? diff_mant : sum_mant;
        if (s1_nan) begin
            res_sign = 1'b0;
            res_exp  = EXP_MAX;
            res_mant = '0;
        end else if (s1_inf) begin
            res_sign = s1_inf_sign;
            res_exp  = EXP_MAX;
            res_mant = '0;
        end else if (s1_eff_sub && (diff_mant == '0)) begin
            res_sign = 1'b0;
            res_exp  = '0;
        end
    end

    // Stage 2 register: result only changes when downstream has taken the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_mant  <= '0;
            s2_inf   <= 1'b0;
            s2_nan   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= res_sign;
                s2_exp  <= res_exp;
                s2_mant <= res_mant;
                s2_inf  <= s1_inf;
                s2_nan  <= s1_nan;
            end
        end
    end
endmodule

// File: tb/tb_fp_align_add.sv
// Bench for fp_align_add: directed literal cases, stall/reset scenarios and a randomized
// stream compared every cycle against a plain-arithmetic model of the align/add rules.
module tb_fp_align_add;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        inf;
        logic        nan;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];

    fp_align_add_if bus ();

    fp_align_add dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference result computed from the rules with integer arithmetic.
    function automatic res_t model(input logic sub, input logic sa, input logic sb,
                                   input logic [7:0] ea, input logic [7:0] eb,
                                   input logic [23:0] ma, input logic [23:0] mb);
        res_t   r;
        logic   sbe, nan_a, nan_b, inf_a, inf_b, sbig, ssmall;
        logic [7:0] ebig;
        int     eea, eeb, d;
        longint ka, kb, mbig, ms, al, pw, rr;
        r     = '0;
        sbe   = sb ^ sub;
        nan_a = (ea == 8'hFF) && (ma[22:0] != 0);
        nan_b = (eb == 8'hFF) && (mb[22:0] != 0);
        inf_a = (ea == 8'hFF) && (ma[22:0] == 0);
        inf_b = (eb == 8'hFF) && (mb[22:0] == 0);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sbe))) begin
            r.exp = 8'hFF;
            r.nan = 1'b1;
            return r;
        end
        if (inf_a || inf_b) begin
            r.exp  = 8'hFF;
            r.inf  = 1'b1;
            r.sign = inf_a ? sa : sbe;
            return r;
        end
        eea = (ea == 0) ? 1 : int'(ea);
        eeb = (eb == 0) ? 1 : int'(eb);
        ka  = longint'(eea) * 16777216 + longint'(ma);
        kb  = longint'(eeb) * 16777216 + longint'(mb);
        if (ka >= kb) begin
            sbig = sa;  ssmall = sbe; ebig = ea; mbig = longint'(ma); ms = longint'(mb); d = eea - eeb;
        end else begin
            sbig = sbe; ssmall = sa;  ebig = eb; mbig = longint'(mb); ms = longint'(ma); d = eeb - eea;
        end
        if (d >= 27) begin
            al = (ms != 0) ? 1 : 0;
        end else begin
            pw = longint'(1) << d;
            al = (ms * 8) / pw;
            if (((ms * 8) % pw) != 0) al = al | 1;
        end
        if (sbig != ssmall) begin
            rr = mbig * 8 - al;
            if (rr == 0) begin
                r.sign = 1'b0;
                r.exp  = 8'd0;
            end else begin
                r.sign = sbig;
                r.exp  = ebig;
            end
        end else begin
            rr     = mbig * 8 + al;
            r.sign = sbig;
            r.exp  = ebig;
        end
        r.mant = 28'(rr);
        return r;
    endfunction

    // Scoreboard: queue a model result per accepted operand set, compare the head on every valid cycle.
    always @(negedge clk or negedge rst_n) begin
        res_t act;
        res_t expv;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                act = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inf, bus.out_nan};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_output: got %h, no result outstanding", act);
                end else begin
                    expv = exp_q[0];
                    if (act !== expv) begin
                        fails++;
                        $display("[TB] FAIL model_compare: got s=%0b e=%h m=%h inf=%0b nan=%0b, expected s=%0b e=%h m=%h inf=%0b nan=%0b",
                                 act.sign, act.exp, act.mant, act.inf, act.nan,
                                 expv.sign, expv.exp, expv.mant, expv.inf, expv.nan);
                    end
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.op_sub, bus.sign_a, bus.sign_b, bus.exp_a, bus.exp_b,
                                      bus.mant_a, bus.mant_b));
        end
    end

    task automatic checkOutput(input string name, input res_t expv);
        res_t act;
        act = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_inf, bus.out_nan};
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got s=%0b e=%h m=%h inf=%0b nan=%0b, expected s=%0b e=%h m=%h inf=%0b nan=%0b",
                     name, act.sign, act.exp, act.mant, act.inf, act.nan,
                     expv.sign, expv.exp, expv.mant, expv.inf, expv.nan);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Present one operand set (called just after a rising edge) and return just after it is accepted.
    task automatic applyStimulus(input logic sub, input logic sa, input logic sb,
                                 input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb);
        bit ok;
        ok = 1'b0;
        bus.op_sub   = sub;
        bus.sign_a   = sa;
        bus.sign_b   = sb;
        bus.exp_a    = ea;
        bus.exp_b    = eb;
        bus.mant_a   = ma;
        bus.mant_b   = mb;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    // Single operation on an idle pipeline: checks 2-cycle latency and the literal result.
    task automatic runDirected(input string name, input logic sub, input logic sa, input logic sb,
                               input logic [7:0] ea, input logic [7:0] eb,
                               input logic [23:0] ma, input logic [23:0] mb, input res_t expv);
        int lat;
        bus.out_ready = 1'b1;
        applyStimulus(sub, sa, sb, ea, eb, ma, mb);
        bus.in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        checkValue({name, "_latency"}, lat, 2);
        checkOutput(name, expv);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        checkValue(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic void genOperand(output logic s, output logic [7:0] e, output logic [23:0] m,
                                       input logic [7:0] near, input bit use_near);
        int kind, ne;
        kind = $urandom_range(0, 19);
        s    = 1'($urandom_range(0, 1));
        if (kind == 0) begin
            e = 8'd0;  m = 24'd0;
        end else if (kind == 1) begin
            e = 8'd0;  m = {1'b0, 23'($urandom)};
        end else if (kind == 2) begin
            e = 8'hFF; m = 24'h800000;
        end else if (kind == 3) begin
            e = 8'hFF; m = 24'h800000 | 24'($urandom_range(1, 8388607));
        end else begin
            if (use_near) begin
                ne = int'(near) + $urandom_range(0, 60) - 30;
                if (ne < 1) ne = 1;
                if (ne > 254) ne = 254;
                e = 8'(ne);
            end else begin
                e = 8'($urandom_range(1, 254));
            end
            m = {1'b1, 23'($urandom)};
        end
    endfunction

    // Watchdog so the run always ends even if the handshake locks up.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       sa, sb, sub, accepted, presenting;
        logic [7:0] ea, eb;
        logic [23:0] ma, mb;
        int         sent, stale;

        bus.in_valid = 1'b0; bus.op_sub = 1'b0; bus.sign_a = 1'b0; bus.sign_b = 1'b0;
        bus.exp_a = '0; bus.exp_b = '0; bus.mant_a = '0; bus.mant_b = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkValue("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_fields", '{1'b0, 8'd0, 28'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkValue("ready_after_reset", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        runDirected("one_plus_one",  1'b0, 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, '{1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0});
        runDirected("one_minus_one", 1'b1, 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, '{1'b0, 8'd0, 28'h0, 1'b0, 1'b0});
        runDirected("1p5_plus_0p5",  1'b0, 1'b0, 1'b0, 8'd127, 8'd126, 24'hC00000, 24'h800000, '{1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0});
        runDirected("0p5_plus_1p5",  1'b0, 1'b0, 1'b0, 8'd126, 8'd127, 24'h800000, 24'hC00000, '{1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0});
        runDirected("one_plus_tiny", 1'b0, 1'b0, 1'b0, 8'd127, 8'd97,  24'h800000, 24'h800000, '{1'b0, 8'd127, 28'h4000001, 1'b0, 1'b0});
        runDirected("inf_minus_inf", 1'b0, 1'b0, 1'b1, 8'd255, 8'd255, 24'h800000, 24'h800000, '{1'b0, 8'd255, 28'h0, 1'b0, 1'b1});
        runDirected("inf_plus_one",  1'b0, 1'b0, 1'b0, 8'd255, 8'd127, 24'h800000, 24'h800000, '{1'b0, 8'd255, 28'h0, 1'b1, 1'b0});
        runDirected("qnan_input",    1'b0, 1'b0, 1'b0, 8'd255, 8'd127, 24'hC00000, 24'h800000, '{1'b0, 8'd255, 28'h0, 1'b0, 1'b1});
        runDirected("snan_input",    1'b0, 1'b1, 1'b0, 8'd127, 8'd255, 24'h800000, 24'h800001, '{1'b0, 8'd255, 28'h0, 1'b0, 1'b1});
        runDirected("neg_zero_add",  1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   24'h000000, 24'h000000, '{1'b1, 8'd0, 28'h0, 1'b0, 1'b0});

        // Stall: two sets enter, output blocks, third set must wait; then drain in order.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd120, 8'd120, 24'h800000, 24'h800000);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd121, 8'd121, 24'h800000, 24'h800000);
        bus.out_ready = 1'b0;
        bus.exp_a = 8'd122; bus.exp_b = 8'd122;
        @(negedge clk);
        checkValue("stall_in_ready", int'(bus.in_ready), 0);
        checkValue("stall_out_exp", int'(bus.out_exp), 120);
        repeat (3) @(negedge clk);
        checkValue("stall_in_ready_held", int'(bus.in_ready), 0);
        checkValue("stall_out_exp_held", int'(bus.out_exp), 120);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd122, 8'd122, 24'h800000, 24'h800000);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd123, 8'd123, 24'h800000, 24'h800000);
        waitDrain("stall_drain");

        // Randomized stream with random gaps and random downstream backpressure.
        sent = 0;
        presenting = 1'b0;
        for (int cyc = 0; cyc < 20000 && (sent < 300 || presenting); cyc++) begin
            if (!presenting && sent < 300 && $urandom_range(0, 3) != 0) begin
                genOperand(sa, ea, ma, 8'd0, 1'b0);
                if ($urandom_range(0, 7) == 0) begin
                    sb = 1'($urandom_range(0, 1)); eb = ea; mb = ma;
                end else begin
                    genOperand(sb, eb, mb, ea, $urandom_range(0, 1) == 1);
                end
                sub = 1'($urandom_range(0, 1));
                bus.op_sub = sub; bus.sign_a = sa; bus.sign_b = sb;
                bus.exp_a = ea; bus.exp_b = eb; bus.mant_a = ma; bus.mant_b = mb;
                bus.in_valid = 1'b1;
                presenting = 1'b1;
                sent++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                presenting   = 1'b0;
                bus.in_valid = 1'b0;
            end
        end
        checkValue("random_sent", sent, 300);
        waitDrain("random_drain");

        // Reset in the middle of a held result: output must vanish at once and not return.
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd130, 8'd128, 24'hA00000, 24'h900000);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd130, 8'd128, 24'hA00000, 24'h900000);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkValue("pre_reset_out_valid", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async_reset_out_valid", int'(bus.out_valid), 0);
        checkValue("async_reset_out_exp", int'(bus.out_exp), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checkValue("no_stale_after_reset", stale, 0);
        @(posedge clk);
        #1;
        runDirected("post_reset_add", 1'b0, 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, '{1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Two-stage pipelined exponent-align and mantissa add/subtract stage for FP32 addition.
- Sits directly downstream of the operand unpacker. Consumes per-operand sign, 8-bit biased exponent and 24-bit mantissa with the hidden bit already inserted.
- Produces an unnormalized sum (sign, exponent, 28-bit mantissa with carry/guard/round/sticky) for the normalize/round stage.
- valid/ready handshake on both sides; throughput of one operation per cycle.

Parameters:
- EXP_W, 8, exponent width
- MANT_W, 24, mantissa width including the hidden bit
- OUT_MANT_W, 28, output mantissa width = carry + MANT_W + G + R + S (fixed to MANT_W+4)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  stage can accept an operand set this cycle
- op_sub  input  1  1 = compute a-b (sign_b inverted internally)
- sign_a, sign_b  input  1 each  operand signs
- exp_a, exp_b  input  EXP_W each  biased exponents (0 = zero/denormal)
- mant_a, mant_b  input  MANT_W each  mantissas, hidden bit in MSB
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sign  output  1  result sign
- out_exp  output  EXP_W  exponent of the larger operand
- out_mant  output  OUT_MANT_W  {carry, mant[23:0], G, R, S}, unnormalized
- out_inf  output  1  result is ±infinity
- out_nan  output  1  result is NaN

Behaviour:
- Reset (async, rst_n=0): both stage valid flags = 0; out_valid=0, out_sign=0, out_exp=0, out_mant=0, out_inf=0, out_nan=0. in_ready goes to 1 once reset releases. In-flight operations are discarded.
- Handshake:
  - s2_ready = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_ready (combinational).
  - Stage loads on valid & ready.
  - Output fields hold stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input accept to out_valid when not stalled.
- Stage 1 (compare/align):
  - Effective sign b = sign_b ^ op_sub.
  - Effective exponent = (exp==0) ? 1 : exp.
  - Larger operand = larger {eff_exp, mant}; on equality, a is the larger.
  - d = eff_exp_big - eff_exp_small.
  - Extend the small mantissa to 27 bits ({mant,3'b000}) and shift right by d. Sticky = OR of all bits shifted past bit 0, ORed into bit 0.
  - If d >= 27: aligned value = {26'b0, |mant_small}.
  - Register big mantissa {mant,3'b000}, aligned small, sign_big, effective sub flag (sign_big ^ sign_small), and exp_big (raw exponent, not effective).
- Stage 2 (add/sub):
  - Add: out_mant = big + small (28 bits, carry in MSB), out_sign = sign_big.
  - Sub: out_mant = big - small (never negative, MSB=0), out_sign = sign_big.
  - If the sub result is 0: out_sign=0, out_exp=0.
- Specials (evaluated in stage 1, carried through stage 2):
  - NaN operand = exp==255 & mant[22:0]!=0.
  - Inf operand = exp==255 & mant[22:0]==0.
  - out_nan=1 if either operand is NaN, or both are Inf with differing effective signs.
  - Otherwise out_inf=1 if any operand is Inf; out_sign = that Inf's effective sign.
  - When out_nan or out_inf: out_exp=255, out_mant=0. For NaN, out_sign=0.
- Both operands zero: out_mant=0, out_exp=0. out_sign = sign_a & sign_b_eff for add, 0 when the effective op is sub.
- Back-to-back: a full pipeline with out_ready=1 accepts and retires one set per cycle, no bubbles.

Test Plan:
- 1.0+1.0 (exp 127, mant 0x800000 both, op_sub=0) -> out_exp=127, out_mant=0x8000000, out_sign=0; out_valid exactly 2 cycles after accept.
- 1.0-1.0 (op_sub=1) -> out_mant=0, out_exp=0, out_sign=0, out_nan=0.
- 1.5+0.5 (a: exp127 mant 0xC00000; b: exp126 mant 0x800000) -> d=1, out_mant=0x8000000, out_exp=127. Swapped operand order gives an identical result.
- 1.0+2^-30 (b exp 97) -> d=30>=27, out_mant=0x4000001 (sticky set), out_exp=127.
- +Inf + -Inf (exp 255, mant 0x800000, signs 0/1) -> out_nan=1, out_exp=255, out_mant=0. +Inf+1.0 -> out_inf=1, out_sign=0. Signalling/quiet NaN input -> out_nan=1.
- Stall/reset:
  - Send 4 back-to-back sets, hold out_ready=0 from cycle 3 -> in_ready drops once both stages are full, out fields stable; releasing out_ready drains in order, no loss or duplication.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately (asynchronous); no stale result after release.
